// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a stable
// synchronized lock, then releases a clean system reset; restarts on loss, timeout or request.
`timescale 1ns/1ps
module pll_reset_ctrl #(
    parameter int RST_PULSE_CYC    = 50,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_W = $clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC)) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    // Pulse and timeout leave on the last counted cycle; the stable window needs one
    // extra lock_s-high cycle because the entry cycle into STABLE is not counted.
    localparam cnt_t PULSE_END   = cnt_t'(RST_PULSE_CYC - 1);
    localparam cnt_t TIMEOUT_END = cnt_t'(LOCK_TIMEOUT_CYC - 1);
    localparam cnt_t STABLE_END  = cnt_t'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_WAIT   = 5'b00010,
        S_STABLE = 5'b00100,
        S_READY  = 5'b01000,
        S_FAIL   = 5'b10000
    } state_t;

    state_t                 state;
    cnt_t                   cnt;
    logic [3:0]             retry;
    logic [3:0]             retry_inc;
    logic                   lost_pend;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        retry_inc = (retry == 4'd15) ? 4'd15 : retry + 4'd1;
    end

    // Outputs are decoded from the current state one edge later, so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry     <= '0;
            lost_pend <= 1'b0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
            fail      <= 1'b0;
        end else begin
            pll_reset <= (state == S_RESET) || (state == S_FAIL);
            sys_rst_n <= (state == S_READY);
            locked    <= (state == S_READY);
            fail      <= (state == S_FAIL);
            lock_lost <= lost_pend;
            retry_cnt <= retry;
            lost_pend <= 1'b0;

            case (state)
                S_RESET: begin
                    if (cnt == PULSE_END) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_WAIT: begin
                    if (relock_req) begin
                        state <= S_RESET;
                        cnt   <= '0;
                    end else if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_END) begin
                        retry <= retry_inc;
                        state <= (retry_inc >= RETRY_LIMIT) ? S_FAIL : S_RESET;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_STABLE: begin
                    if (relock_req) begin
                        state <= S_RESET;
                        cnt   <= '0;
                    end else if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_END) begin
                        state <= S_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                S_READY: begin
                    if (!lock_s || relock_req) begin
                        state     <= S_RESET;
                        cnt       <= '0;
                        lost_pend <= !lock_s;
                    end
                end
                S_FAIL: begin
                    if (relock_req) begin
                        state <= S_RESET;
                        cnt   <= '0;
                        retry <= '0;
                    end
                end
                default: begin
                    state <= S_RESET;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
